zcrv_wb_stage: RTL and testbench

ZCRV_WB_STAGE -- requirements
Module: zcrv_wb_stage

---
 rtl/zcrv_wb_stage_pkg.sv | 42 ++++
 rtl/zcrv_wb_stage_load_align.sv | 47 ++++
 rtl/zcrv_wb_stage.sv | 113 +++++++++++
 tb/tb_zcrv_wb_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/zcrv_wb_stage_pkg.sv
// zcrv_wb_stage_pkg
//   Shared project defines and the writeback-stage package.
//   Defines:  ZCRV_XLEN, ZCRV_REG_SIZE, ZCRV_F3_{LB,LH,LW,LBU,LHU}
//   Package:  ld_funct3_e (load type encodings), SB_W (scoreboard width),
//             ld_legal() (is a funct3 a supported load type).
//   This file must be compiled before the other zcrv files.

`ifndef ZCRV_DEFINES_V
`define ZCRV_DEFINES_V
`define ZCRV_XLEN      32
`define ZCRV_REG_SIZE  5
`define ZCRV_F3_LB     3'b000
`define ZCRV_F3_LH     3'b001
`define ZCRV_F3_LW     3'b010
`define ZCRV_F3_LBU    3'b100
`define ZCRV_F3_LHU    3'b101
`endif

package zcrv_wb_stage_pkg;

    // Pending-load scoreboard is always one bit per architectural register.
    localparam int unsigned SB_W = 32;

    typedef enum logic [2:0] {
        LD_LB  = `ZCRV_F3_LB,
        LD_LH  = `ZCRV_F3_LH,
        LD_LW  = `ZCRV_F3_LW,
        LD_LBU = `ZCRV_F3_LBU,
        LD_LHU = `ZCRV_F3_LHU
    } ld_funct3_e;

    function automatic logic ld_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            `ZCRV_F3_LB, `ZCRV_F3_LH, `ZCRV_F3_LW,
            `ZCRV_F3_LBU, `ZCRV_F3_LHU: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/zcrv_wb_stage_load_align.sv
// zcrv_load_align
//   Combinational load-data formatter. Picks the byte/halfword addressed by
//   addr_lo_i out of the aligned memory word and sign/zero-extends it.
//   Ports:
//     funct3_i  [2:0]       load type
//     addr_lo_i [1:0]       byte address bits [1:0]
//     rdata_i   [XLEN-1:0]  raw aligned word
//     data_o    [XLEN-1:0]  formatted result
//     legal_o               funct3_i is a supported load type

module zcrv_load_align
    import zcrv_wb_stage_pkg::*;
#(
    parameter int XLEN = `ZCRV_XLEN
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            legal_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfwords use addr_lo[1] only; misalignment is screened by the LSU.
    assign byte_sh = {addr_lo_i, 3'b000};
    assign half_sh = {addr_lo_i[1], 4'b0000};
    assign byte_v  = rdata_i[byte_sh +: 8];
    assign half_v  = rdata_i[half_sh +: 16];

    always_comb begin
        data_o  = '0;
        legal_o = ld_legal(funct3_i);
        case (funct3_i)
            `ZCRV_F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            `ZCRV_F3_LH:  data_o = {{(XLEN-16){half_v[15]}}, half_v};
            `ZCRV_F3_LW:  data_o = rdata_i;
            `ZCRV_F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
            `ZCRV_F3_LHU: data_o = {{(XLEN-16){1'b0}}, half_v};
            default:      data_o = '0;
        endcase
    end

endmodule

// File: rtl/zcrv_wb_stage.sv
// zcrv_wb_stage
//   Writeback stage: arbitrates between execute results and load returns
//   (loads win, they cannot be stalled), registers the regfile write, and
//   tracks registers with an outstanding load in the sb_busy bitmap.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     ex_valid/ex_ready/ex_wen/ex_rd/ex_data   execute result handshake
//     ld_issue/ld_issue_rd            load dispatched to LSU (sets busy)
//     lsu_valid/lsu_rd/lsu_funct3/lsu_addr_lo/lsu_rdata   load return
//     rd_wr_en/rd_index/rd_data       registered regfile write / bypass
//     sb_busy [31:0]                  pending-load bitmap
//     wb_err                          pulse for an illegal load funct3

module zcrv_wb_stage
    import zcrv_wb_stage_pkg::*;
#(
    parameter int XLEN     = `ZCRV_XLEN,
    parameter int REG_SIZE = `ZCRV_REG_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_wen,
    input  logic [REG_SIZE-1:0] ex_rd,
    input  logic [XLEN-1:0]     ex_data,
    input  logic                ld_issue,
    input  logic [REG_SIZE-1:0] ld_issue_rd,
    input  logic                lsu_valid,
    input  logic [REG_SIZE-1:0] lsu_rd,
    input  logic [2:0]          lsu_funct3,
    input  logic [1:0]          lsu_addr_lo,
    input  logic [XLEN-1:0]     lsu_rdata,
    output logic                rd_wr_en,
    output logic [REG_SIZE-1:0] rd_index,
    output logic [XLEN-1:0]     rd_data,
    output logic [SB_W-1:0]     sb_busy,
    output logic                wb_err
);

    logic                wr_en_q, wr_en_d;
    logic [REG_SIZE-1:0] idx_q,   idx_d;
    logic [XLEN-1:0]     data_q,  data_d;
    logic [SB_W-1:0]     busy_q,  busy_d;
    logic                err_q,   err_d;

    logic [XLEN-1:0]     ld_data;
    logic                ld_ok;

    zcrv_load_align #(.XLEN(XLEN)) u_load_align (
        .funct3_i  (lsu_funct3),
        .addr_lo_i (lsu_addr_lo),
        .rdata_i   (lsu_rdata),
        .data_o    (ld_data),
        .legal_o   (ld_ok)
    );

    // Load returns have no backpressure, so EX is only taken when the LSU is quiet.
    assign ex_ready = !lsu_valid;

    always_comb begin
        wr_en_d = 1'b0;
        err_d   = 1'b0;
        idx_d   = idx_q;
        data_d  = data_q;
        if (lsu_valid) begin
            // Illegal load types leave index/data untouched and only flag an error.
            if (ld_ok) begin
                wr_en_d = (lsu_rd != '0);
                idx_d   = lsu_rd;
                data_d  = ld_data;
            end else begin
                err_d   = 1'b1;
            end
        end else if (ex_valid) begin
            wr_en_d = ex_wen && (ex_rd != '0);
            idx_d   = ex_rd;
            data_d  = ex_data;
        end
    end

    // Scoreboard: a new issue overrides a same-cycle return to the same index.
    always_comb begin
        busy_d    = '0;
        for (int i = 1; i < SB_W; i++) begin
            busy_d[i] = (ld_issue && (ld_issue_rd == REG_SIZE'(i))) ||
                        (busy_q[i] && !(lsu_valid && (lsu_rd == REG_SIZE'(i))));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wr_en_q <= wr_en_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign rd_wr_en = wr_en_q;
    assign rd_index = idx_q;
    assign rd_data  = data_q;
    assign sb_busy  = busy_q;
    assign wb_err   = err_q;

endmodule

// File: tb/tb_zcrv_wb_stage.sv
module tb_zcrv_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_wen;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_addr_lo;
    logic [31:0] lsu_rdata;
    logic        rd_wr_en;
    logic [4:0]  rd_index;
    logic [31:0] rd_data;
    logic [31:0] sb_busy;
    logic        wb_err;

    zcrv_wb_stage #(.XLEN(32), .REG_SIZE(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen),
        .ex_rd(ex_rd), .ex_data(ex_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_funct3(lsu_funct3),
        .lsu_addr_lo(lsu_addr_lo), .lsu_rdata(lsu_rdata),
        .rd_wr_en(rd_wr_en), .rd_index(rd_index), .rd_data(rd_data),
        .sb_busy(sb_busy), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic        m_wr, m_err;
    logic [4:0]  m_idx;
    logic [31:0] m_data, m_busy;

    function automatic bit ld_ok(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    // Byte/half extracted by shifting the word; sign extension by subtracting 2^n.
    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
        logic [31:0] b, h, r;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    r = (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    r = (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2:    r = w;
            3'd4:    r = b;
            3'd5:    r = h;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] busy_next(input logic [31:0] b, input logic li,
                                              input logic [4:0] ir, input logic lv,
                                              input logic [4:0] lr);
        logic [31:0] t;
        t = b;
        if (lv) t[lr] = 1'b0;
        if (li && ir != 5'd0) t[ir] = 1'b1;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr <= 1'b0; m_err <= 1'b0; m_idx <= '0; m_data <= '0; m_busy <= '0;
        end else begin
            m_wr  <= 1'b0;
            m_err <= 1'b0;
            if (lsu_valid) begin
                if (ld_ok(lsu_funct3)) begin
                    m_wr   <= (lsu_rd != 5'd0);
                    m_idx  <= lsu_rd;
                    m_data <= ld_val(lsu_funct3, lsu_addr_lo, lsu_rdata);
                end else begin
                    m_err  <= 1'b1;
                end
            end else if (ex_valid) begin
                m_wr   <= ex_wen && (ex_rd != 5'd0);
                m_idx  <= ex_rd;
                m_data <= ex_data;
            end
            m_busy <= busy_next(m_busy, ld_issue, ld_issue_rd, lsu_valid, lsu_rd);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        chk("rd_wr_en", 32'(rd_wr_en), 32'(m_wr));
        chk("rd_index", 32'(rd_index), 32'(m_idx));
        chk("rd_data",  rd_data, m_data);
        chk("sb_busy",  sb_busy, m_busy);
        chk("wb_err",   32'(wb_err), 32'(m_err));
        chk("ex_ready", 32'(ex_ready), 32'(!lsu_valid));
    endtask

    task automatic idle();
        ex_valid = 0; ex_wen = 0; ex_rd = 0; ex_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_addr_lo = 0; lsu_rdata = 0;
    endtask

    task automatic ex_t(input logic wen, input logic [4:0] rd, input logic [31:0] d);
        idle();
        ex_valid = 1; ex_wen = wen; ex_rd = rd; ex_data = d;
    endtask

    task automatic ld_t(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                        input logic [31:0] w);
        idle();
        lsu_valid = 1; lsu_rd = rd; lsu_funct3 = f3; lsu_addr_lo = a; lsu_rdata = w;
    endtask

    localparam logic [31:0] W = 32'h80FF_7F01;

    initial begin
        idle();
        rst_n = 0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(rd_wr_en), 0);
        chk("rst_busy",  sb_busy, 0);
        chk("rst_data",  rd_data, 0);
        rst_n = 1;
        tick();

        // basic EX write
        ex_t(1, 5, 32'h1234_5678); tick();
        chk("ex_wr",  32'(rd_wr_en), 1);
        chk("ex_idx", 32'(rd_index), 5);
        chk("ex_dat", rd_data, 32'h1234_5678);
        idle(); tick();
        chk("ex_wr_off", 32'(rd_wr_en), 0);
        chk("ex_hold",   rd_data, 32'h1234_5678);

        // load formatting
        ld_t(10, 3'b000, 3, W); tick();
        chk("lb3",  rd_data, 32'hFFFF_FF80);
        chk("lb3_idx", 32'(rd_index), 10);
        ld_t(11, 3'b100, 1, W); tick();
        chk("lbu1", rd_data, 32'h0000_007F);
        ld_t(12, 3'b001, 2, W); tick();
        chk("lh2",  rd_data, 32'hFFFF_80FF);
        ld_t(13, 3'b101, 0, W); tick();
        chk("lhu0", rd_data, 32'h0000_7F01);
        ld_t(14, 3'b001, 3, W); tick();
        chk("lh3",  rd_data, 32'hFFFF_80FF);
        ld_t(15, 3'b010, 0, W); tick();
        chk("lw",   rd_data, W);
        ld_t(16, 3'b000, 0, W); tick();
        chk("lb0",  rd_data, 32'h0000_0001);

        // simultaneous EX and LSU: load first, EX next cycle
        ld_t(20, 3'b010, 0, 32'hCAFE_F00D);
        ex_valid = 1; ex_wen = 1; ex_rd = 21; ex_data = 32'h0BAD_BEEF;
        #1 chk("ex_ready_lo", 32'(ex_ready), 0);
        tick();
        chk("arb_ld_idx", 32'(rd_index), 20);
        chk("arb_ld_dat", rd_data, 32'hCAFE_F00D);
        lsu_valid = 0;
        #1 chk("ex_ready_hi", 32'(ex_ready), 1);
        tick();
        chk("arb_ex_wr",  32'(rd_wr_en), 1);
        chk("arb_ex_idx", 32'(rd_index), 21);
        chk("arb_ex_dat", rd_data, 32'h0BAD_BEEF);
        idle(); tick();
        chk("arb_done", 32'(rd_wr_en), 0);

        // scoreboard
        ld_issue = 1; ld_issue_rd = 7; tick();
        chk("sb7_set", 32'(sb_busy[7]), 1);
        idle(); tick();
        chk("sb7_hold", 32'(sb_busy[7]), 1);
        ld_t(7, 3'b010, 0, 32'h77); tick();
        chk("sb7_clr", 32'(sb_busy[7]), 0);
        chk("sb7_wr",  32'(rd_wr_en), 1);
        idle(); ld_issue = 1; ld_issue_rd = 7; tick();
        ld_t(7, 3'b010, 0, 32'h78); ld_issue = 1; ld_issue_rd = 7; tick();
        chk("sb7_same", 32'(sb_busy[7]), 1);
        ld_t(7, 3'b010, 0, 32'h79); tick();
        chk("sb7_clr2", 32'(sb_busy[7]), 0);
        idle(); ld_issue = 1; ld_issue_rd = 0; tick();
        chk("sb0", sb_busy, 0);

        // suppressed writes
        ex_t(1, 0, 32'hDEAD_0000); tick();
        chk("x0_wr", 32'(rd_wr_en), 0);
        ex_t(0, 9, 32'h0000_BEEF); tick();
        chk("nowen_wr", 32'(rd_wr_en), 0);

        // illegal funct3 clears busy, pulses error once
        idle(); ld_issue = 1; ld_issue_rd = 3; tick();
        ld_t(3, 3'b011, 0, 32'h1111_2222); tick();
        chk("ill_err",  32'(wb_err), 1);
        chk("ill_wr",   32'(rd_wr_en), 0);
        chk("ill_busy", 32'(sb_busy[3]), 0);
        idle(); tick();
        chk("ill_err_off", 32'(wb_err), 0);

        // reset mid-operation discards the pending write and busy bit
        ex_t(1, 9, 32'h9999_9999); ld_issue = 1; ld_issue_rd = 9;
        #2 rst_n = 0;
        tick();
        chk("rmid_wr",   32'(rd_wr_en), 0);
        chk("rmid_busy", sb_busy, 0);
        idle(); tick();
        rst_n = 1;
        tick(); tick();
        chk("rpost_wr",   32'(rd_wr_en), 0);
        chk("rpost_busy", sb_busy, 0);
        chk("rpost_data", rd_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
